// File: rtl/input_debounce_pkg.sv
// Shared constants for the board input conditioning block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package input_pkg;

  localparam int NUM_SW  = 4;
  localparam int NUM_BTN = 4;

  // Button bit positions within btn_raw / btn_level.
  localparam int BTN_N = 0;
  localparam int BTN_E = 1;
  localparam int BTN_S = 2;
  localparam int BTN_W = 3;

  // Simulation-friendly default; the board build overrides it to 500000.
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/input_debounce_if.sv
// Bundles the raw board inputs and the conditioned outputs of input_debounce.
// Latency: n/a (wiring only).
// Backpressure: none; consumers sample the pulses every cycle.
//
// Signals: sw_raw/btn_raw (raw pins), sw0..sw3 (levels), nb/eb/sb/wb (press
// pulses), btn_level (button levels), any_press (OR of the pulses).
interface input_debounce_if;
  import input_pkg::*;

  logic [NUM_SW-1:0]  sw_raw;
  logic [NUM_BTN-1:0] btn_raw;
  logic               sw0, sw1, sw2, sw3;
  logic               nb, eb, sb, wb;
  logic [NUM_BTN-1:0] btn_level;
  logic               any_press;

  // master: the board / bench side that drives the raw pins.
  modport master (
    output sw_raw, btn_raw,
    input  sw0, sw1, sw2, sw3, nb, eb, sb, wb, btn_level, any_press
  );

  // slave: the conditioning block itself.
  modport slave (
    input  sw_raw, btn_raw,
    output sw0, sw1, sw2, sw3, nb, eb, sb, wb, btn_level, any_press
  );
endinterface

// File: rtl/input_debounce_channel.sv
// One input channel: SYNC_STAGES-deep synchroniser then a stability counter.
// Latency: raw edge before CLK edge k shows on level after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
// Backpressure: none; level is a free-running output.
//
// Ports: CLK, CLR (async active-high), raw (asynchronous pin), level (debounced).
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   st;
  logic [CNT_W-1:0]       cnt;

  assign s     = sync[SYNC_STAGES-1];
  assign level = st;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Any sample matching st (including a one-cycle glitch back) restarts the
  // count, so only an unbroken run of DEBOUNCE_CYCLES new samples is accepted.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st  <= 1'b0;
      cnt <= '0;
    end else if (s == st) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      st  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/input_debounce.sv
// Debounces 4 switches (levels out) and 4 buttons (registered press pulses + any_press).
// Latency: level after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, press pulse one edge later.
// Backpressure: none; pulses last one cycle and must be sampled every cycle.
//
// Ports: CLK, CLR (async active-high), io (input_debounce_if.slave).
// Optional: define BTN_REPEAT_EN for auto-repeat every REPEAT_CYCLES while held.
module input_debounce
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             CLK,
  input  logic             CLR,
  input_debounce_if.slave  io
);

  logic [NUM_SW-1:0]  sw_st;
  logic [NUM_BTN-1:0] btn_st;
  logic [NUM_BTN-1:0] btn_st_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pulse_nxt;
  logic [NUM_BTN-1:0] pulse;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .CLK   (CLK),
      .CLR   (CLR),
      .raw   (io.sw_raw[i]),
      .level (sw_st[i])
    );
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .CLK   (CLK),
      .CLR   (CLR),
      .raw   (io.btn_raw[i]),
      .level (btn_st[i])
    );
  end

  assign rise = btn_st & ~btn_st_d;

`ifdef BTN_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt;
  logic [NUM_BTN-1:0]            rep_fire;

  // The counter restarts on the initial press, so repeats land exactly
  // REPEAT_CYCLES after the previous pulse for as long as st stays high.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rep_fire[i] = btn_st[i] & ~rise[i] & (rep_cnt[i] == REP_LAST);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rep_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!btn_st[i] || rise[i] || rep_fire[i]) begin
          rep_cnt[i] <= '0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pulse_nxt = rise | rep_fire;
`else
  // Repeat interval has no meaning without the repeat logic.
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = |REPEAT_CYCLES;

  assign pulse_nxt = rise;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      btn_st_d <= '0;
      pulse    <= '0;
    end else begin
      btn_st_d <= btn_st;
      pulse    <= pulse_nxt;
    end
  end

  assign io.sw0       = sw_st[0];
  assign io.sw1       = sw_st[1];
  assign io.sw2       = sw_st[2];
  assign io.sw3       = sw_st[3];
  assign io.nb        = pulse[BTN_N];
  assign io.eb        = pulse[BTN_E];
  assign io.sb        = pulse[BTN_S];
  assign io.wb        = pulse[BTN_W];
  assign io.btn_level = btn_st;
  assign io.any_press = |pulse;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_CYCLES=8.
// Expected press pulses are queued with their due cycle when stimulus is driven.
// A negedge monitor pops and compares them against the DUT pulse outputs.
module tb_input_debounce;

  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int REP = 8;
  // Raw change driven at a negedge where cyc==c: level visible at c+6, pulse at c+7.
  localparam int LVL_LAT   = SYN + DEB;
  localparam int PULSE_LAT = SYN + DEB + 1;

  logic CLK;
  logic CLR;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    int         due;
    logic [3:0] vec;
  } ev_t;

  ev_t sb_q[$];

  input_debounce_if io ();

  input_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYN),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .io  (io.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h, want %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_press(input int due, input logic [3:0] vec);
    ev_t e;
    e.due = due;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  function automatic logic [3:0] sw_vec();
    return {io.sw3, io.sw2, io.sw1, io.sw0};
  endfunction

  function automatic logic [3:0] pulse_vec();
    return {io.wb, io.sb, io.eb, io.nb};
  endfunction

  // Any pulse must match the queued expectation for this exact cycle; an
  // expectation due now with no pulse also fails.
  always @(negedge CLK) begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    exp_v = 4'b0;
    act_v = pulse_vec();
    if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      if (sb_q[0].due < cyc) check("press_missed", 32'(sb_q[0].due), 32'(cyc));
      exp_v = sb_q[0].vec;
      void'(sb_q.pop_front());
    end
    if (act_v != 4'b0 || exp_v != 4'b0) begin
      check("press", 32'(act_v), 32'(exp_v));
      check("any_press", 32'(io.any_press), 32'(|exp_v));
    end
  end

  initial begin
    int c;
    cyc        = 0;
    errors     = 0;
    checks     = 0;
    CLR        = 1'b1;
    io.sw_raw  = 4'hF;
    io.btn_raw = 4'hF;

    // 1. Reset with all inputs high, then release.
    #12;
    check("rst_sw", 32'(sw_vec()), 32'h0);
    check("rst_btn_level", 32'(io.btn_level), 32'h0);
    check("rst_pulse", 32'({pulse_vec(), io.any_press}), 32'h0);
    tick(2);
    c = cyc;
    CLR = 1'b0;
    expect_press(c + PULSE_LAT, 4'hF);
    tick(10);
    check("held_sw", 32'(sw_vec()), 32'hF);
    check("held_btn_level", 32'(io.btn_level), 32'hF);

    // Asynchronous reset mid-run clears everything before the next edge.
    #2 CLR = 1'b1;
    #1;
    check("mid_rst_sw", 32'(sw_vec()), 32'h0);
    check("mid_rst_btn_level", 32'(io.btn_level), 32'h0);
    check("mid_rst_pulse", 32'({pulse_vec(), io.any_press}), 32'h0);
    io.sw_raw  = 4'h0;
    io.btn_raw = 4'h0;
    tick(2);
    CLR = 1'b0;
    tick(3);

    // Reset during a pending qualification discards it.
    io.btn_raw[1] = 1'b1;
    tick(3);
    #2 CLR = 1'b1;
    #1;
    check("pend_rst_level", 32'(io.btn_level), 32'h0);
    io.btn_raw[1] = 1'b0;
    tick(2);
    CLR = 1'b0;
    tick(10);

    // 2. Clean press on nb, then release (no pulse on release).
    c = cyc;
    io.btn_raw[0] = 1'b1;
    expect_press(c + PULSE_LAT, 4'b0001);
    tick(LVL_LAT - 1);
    check("nb_level_early", 32'(io.btn_level[0]), 32'h0);
    tick(1);
    check("nb_level", 32'(io.btn_level[0]), 32'h1);
    tick(10);
    io.btn_raw[0] = 1'b0;
    tick(12);
    check("nb_released", 32'(io.btn_level[0]), 32'h0);

    // 3. Bounce on wb: high two cycles, low two cycles, for 12 cycles.
    for (int i = 0; i < 12; i++) begin
      io.btn_raw[3] = ((i % 4) < 2);
      tick(1);
    end
    check("wb_bounce_level", 32'(io.btn_level[3]), 32'h0);
    c = cyc;
    io.btn_raw[3] = 1'b1;
    expect_press(c + PULSE_LAT, 4'b1000);
    tick(12);
    io.btn_raw[3] = 1'b0;
    tick(12);

    // 4. Switches produce levels only.
    c = cyc;
    io.sw_raw = 4'b0011;
    tick(LVL_LAT - 1);
    check("sw_early", 32'(sw_vec()), 32'h0);
    tick(1);
    check("sw_level", 32'(sw_vec()), 32'h3);
    tick(5);
    io.sw_raw = 4'b0000;
    tick(10);
    check("sw_clear", 32'(sw_vec()), 32'h0);

    // 5. Simultaneous press of nb and sb.
    c = cyc;
    io.btn_raw = 4'b0101;
    expect_press(c + PULSE_LAT, 4'b0101);
    tick(15);
    io.btn_raw = 4'b0000;
    tick(12);

    // 6. eb held for 30 cycles.
    c = cyc;
    io.btn_raw[1] = 1'b1;
    expect_press(c + PULSE_LAT, 4'b0010);
`ifdef BTN_REPEAT_EN
    expect_press(c + PULSE_LAT + REP, 4'b0010);
    expect_press(c + PULSE_LAT + 2 * REP, 4'b0010);
    expect_press(c + PULSE_LAT + 3 * REP, 4'b0010);
`endif
    tick(30);
    io.btn_raw[1] = 1'b0;
    tick(15);

    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
